// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and helpers for the timer/alarm blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Alarm sequencer states
    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_RING   = 2'd1,
        A_SNOOZE = 2'd2
    } alarm_state_t;

    // Larger of two values, used to size counters shared between phases
    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/sec_down_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sec_down_cnt
//  Description : Loadable seconds down-counter. Clear beats load, load beats
//                a decrement; decrements stop at 1 so the count never wraps.
//                o_last flags the final second of the loaded interval.
//  Revision    : 1.0 - initial release
// ============================================================================
module sec_down_cnt #(
    parameter int W = 6
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_last
);

    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] r_cnt;

    // Countdown register: clear, reload, or step down while above 1
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt > c_one)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == c_one);

endmodule : sec_down_cnt
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl
//  Description : Alarm sequencer fed by the time/alarm comparator level.
//                Rings the buzzer with a 1 Hz on/off pattern, handles
//                snooze re-arm (bounded per alarm event), stop and the
//                ring timeout. All outputs are registered and reflect a
//                state change one mclk after the triggering input.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_ctrl
    import timer_pkg::*;
#(
    parameter int  RING_SEC   = 60,
    parameter int  SNOOZE_SEC = 300,
    parameter int  MAX_SNOOZE = 3,
    localparam int SW         = $clog2(MAX_SNOOZE + 1),
    localparam int CW         = $clog2(max_w(RING_SEC, SNOOZE_SEC) + 1)
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          tick_1hz,
    input  logic          equal,
    input  logic          alarm_en,
    input  logic          stop_btn,
    input  logic          snooze_btn,
    output logic          buzzer,
    output logic          ringing,
    output logic          snoozing,
    output logic [SW-1:0] snooze_cnt,
    output logic [CW-1:0] sec_left
);

    localparam logic [CW-1:0] c_ring_load   = CW'(RING_SEC);
    localparam logic [CW-1:0] c_snooze_load = CW'(SNOOZE_SEC);
    localparam logic [SW-1:0] c_max_snooze  = SW'(MAX_SNOOZE);
    localparam logic [SW-1:0] c_snooze_one  = SW'(1);

    alarm_state_t  r_state;
    alarm_state_t  w_state_nxt;

    logic          r_equal_q;
    logic          w_trigger;

    logic          r_buzzer;
    logic          w_buzzer_nxt;
    logic [SW-1:0] r_snooze_cnt;
    logic [SW-1:0] w_snooze_cnt_nxt;
    logic          r_ringing;
    logic          r_snoozing;

    logic          w_cnt_clr;
    logic          w_cnt_load;
    logic [CW-1:0] w_cnt_load_val;
    logic          w_cnt_dec;
    logic [CW-1:0] w_sec_left;
    logic          w_sec_last;

    // Only a fresh rising edge of the match level, while armed, starts an alarm.
    // Raising alarm_en in the middle of a matching minute is not an edge.
    assign w_trigger = equal & ~r_equal_q & alarm_en;

    // Match level delayed one cycle for edge detection
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_equal_q <= 1'b0;
        end else begin
            r_equal_q <= equal;
        end
    end

    // Shared countdown for the ring and snooze phases
    sec_down_cnt #(
        .W (CW)
    ) u_sec_cnt (
        .mclk       (mclk),
        .rst_n      (rst_n),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_sec_left),
        .o_last     (w_sec_last)
    );

    // State, buzzer phase, snooze count and status flags
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= A_IDLE;
            r_buzzer     <= 1'b0;
            r_snooze_cnt <= '0;
            r_ringing    <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_buzzer     <= w_buzzer_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_ringing    <= (w_state_nxt == A_RING);
            r_snoozing   <= (w_state_nxt == A_SNOOZE);
        end
    end

    // Next state plus counter control. Cancel (alarm_en low or stop) wins over
    // snooze, snooze wins over a tick, and a phase load swallows a same-cycle tick.
    always_comb begin
        w_state_nxt      = r_state;
        w_buzzer_nxt     = r_buzzer;
        w_snooze_cnt_nxt = r_snooze_cnt;
        w_cnt_clr        = 1'b0;
        w_cnt_load       = 1'b0;
        w_cnt_load_val   = c_ring_load;
        w_cnt_dec        = 1'b0;

        case (r_state)
            A_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt      = A_RING;
                    w_cnt_load       = 1'b1;
                    w_cnt_load_val   = c_ring_load;
                    w_snooze_cnt_nxt = '0;
                    w_buzzer_nxt     = 1'b1;
                end
            end

            A_RING: begin
                if (!alarm_en || stop_btn) begin
                    w_state_nxt      = A_IDLE;
                    w_cnt_clr        = 1'b1;
                    w_snooze_cnt_nxt = '0;
                    w_buzzer_nxt     = 1'b0;
                end else if (snooze_btn && (r_snooze_cnt < c_max_snooze)) begin
                    w_state_nxt      = A_SNOOZE;
                    w_cnt_load       = 1'b1;
                    w_cnt_load_val   = c_snooze_load;
                    w_snooze_cnt_nxt = r_snooze_cnt + c_snooze_one;
                    w_buzzer_nxt     = 1'b0;
                end else if (tick_1hz) begin
                    // An exhausted snooze press falls through to here
                    if (w_sec_last) begin
                        w_state_nxt      = A_IDLE;
                        w_cnt_clr        = 1'b1;
                        w_snooze_cnt_nxt = '0;
                        w_buzzer_nxt     = 1'b0;
                    end else begin
                        w_cnt_dec    = 1'b1;
                        w_buzzer_nxt = ~r_buzzer;
                    end
                end
            end

            A_SNOOZE: begin
                if (!alarm_en || stop_btn) begin
                    w_state_nxt      = A_IDLE;
                    w_cnt_clr        = 1'b1;
                    w_snooze_cnt_nxt = '0;
                    w_buzzer_nxt     = 1'b0;
                end else if (tick_1hz) begin
                    if (w_sec_last) begin
                        // Snooze expired: ring again, keeping the used-snooze count
                        w_state_nxt    = A_RING;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = c_ring_load;
                        w_buzzer_nxt   = 1'b1;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt      = A_IDLE;
                w_cnt_clr        = 1'b1;
                w_snooze_cnt_nxt = '0;
                w_buzzer_nxt     = 1'b0;
            end
        endcase
    end

    assign buzzer     = r_buzzer;
    assign ringing    = r_ringing;
    assign snoozing   = r_snoozing;
    assign snooze_cnt = r_snooze_cnt;
    assign sec_left   = w_sec_left;

endmodule : alarm_ctrl
`default_nettype wire
